// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for a cache's downstream word port. It serves one
// 32-bit read or write at a time from an internal word-addressed array and
// completes each request after a fixed, programmable number of cycles.
//
// Ports:
//   clk      clock, rising edge
//   res      asynchronous active-low reset
//   re, we   read / write request (we wins when both are set)
//   addr     byte address; word index = addr[ADDR_WIDTH+1:2]
//   dataIn   write data
//   dataOut  read data (live during a read response, held afterwards)
//   ready    one-cycle completion strobe
//   busy     high while a request is outstanding
//   err      (only with MEM_RESPONDER_ALIGN_CHK_EN) misaligned request,
//            asserted together with ready
//
// Build option: define MEM_RESPONDER_ALIGN_CHK_EN to reject requests whose
// addr[1:0] is non-zero (write dropped, read returns zero, err flagged).
//
// LATENCY must lie in 1..15. TAG names this instance in debug text only.
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2,
    parameter     INIT_FILE  = "",
    parameter     TAG        = "mem"
) (
    input  logic        clk,
    input  logic        res,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        ready,
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    output logic        err,
`endif
    output logic        busy
);

    // state  | meaning
    // S_IDLE | waiting for re/we; request latched on the accepting edge
    // S_WAIT | counting down wait states
    // S_RESP | ready strobe; read data live, write committed at cycle end
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                state, state_next;
    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  wr_q;
    logic                  mis_q;
    logic [3:0]            cnt_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rd_word;
    logic                  accept;
    logic                  mis_req;
    logic                  unused_addr;

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    assign mis_req     = (addr[1:0] != 2'b00);
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];
`else
    assign mis_req     = 1'b0;
    assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

    assign accept  = (state == S_IDLE) && (re || we);
    assign rd_word = mis_q ? 32'h0 : mem[idx_q];

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (re || we) state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q <= 4'd1) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == S_RESP);
        busy    = (state != S_IDLE);
        // Read data is visible in the response cycle itself, then held.
        dataOut = (ready && !wr_q) ? rd_word : rdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
        err     = ready && mis_q;
`endif
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                idx_q   <= addr[ADDR_WIDTH+1:2];
                wdata_q <= dataIn;
                wr_q    <= we;
                mis_q   <= mis_req;
                cnt_q   <= CNT_LOAD;
            end else if (state == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state == S_RESP && !wr_q) rdata_q <= rd_word;
        end
    end

    // Array is never reset; an async reset forces state to S_IDLE so a
    // pending write cannot commit.
    always_ff @(posedge clk) begin
        if (state == S_RESP && wr_q && !mis_q) mem[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    typedef struct {
        int          k;
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    localparam int LAT [3] = '{1, 2, 4};

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        re_s   [3];
    logic        we_s   [3];
    logic [31:0] addr_s [3];
    logic [31:0] din_s  [3];
    logic [31:0] dout_s [3];
    logic        rdy_s  [3];
    logic        busy_s [3];
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    logic        err_s  [3];
`endif

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    mem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .res(res), .re(re_s[0]), .we(we_s[0]),
        .addr(addr_s[0]), .dataIn(din_s[0]), .dataOut(dout_s[0]), .ready(rdy_s[0]),
        .err(err_s[0]), .busy(busy_s[0]));
    mem_responder #(.LATENCY(2)) u_l2 (.clk(clk), .res(res), .re(re_s[1]), .we(we_s[1]),
        .addr(addr_s[1]), .dataIn(din_s[1]), .dataOut(dout_s[1]), .ready(rdy_s[1]),
        .err(err_s[1]), .busy(busy_s[1]));
    mem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .res(res), .re(re_s[2]), .we(we_s[2]),
        .addr(addr_s[2]), .dataIn(din_s[2]), .dataOut(dout_s[2]), .ready(rdy_s[2]),
        .err(err_s[2]), .busy(busy_s[2]));
`else
    mem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .res(res), .re(re_s[0]), .we(we_s[0]),
        .addr(addr_s[0]), .dataIn(din_s[0]), .dataOut(dout_s[0]), .ready(rdy_s[0]),
        .busy(busy_s[0]));
    mem_responder #(.LATENCY(2)) u_l2 (.clk(clk), .res(res), .re(re_s[1]), .we(we_s[1]),
        .addr(addr_s[1]), .dataIn(din_s[1]), .dataOut(dout_s[1]), .ready(rdy_s[1]),
        .busy(busy_s[1]));
    mem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .res(res), .re(re_s[2]), .we(we_s[2]),
        .addr(addr_s[2]), .dataIn(din_s[2]), .dataOut(dout_s[2]), .ready(rdy_s[2]),
        .busy(busy_s[2]));
`endif

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endfunction

    // Monitor: every ready pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rdy_s[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_ready", k, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk(e.k == k, "ready_instance", k, e.k);
                    if (e.rd) chk(dout_s[k] === e.data, "read_data", dout_s[k], e.data);
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
                    chk(err_s[k] === e.err, "err_flag", {31'b0, err_s[k]}, {31'b0, e.err});
`endif
                end
            end
        end
    end

    // One transaction: drive, accept, optionally poke re during the wait,
    // and check the ready latency.
    task automatic xact(input int k, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit poke,
                        input logic [31:0] exp_d, input bit exp_e);
        int n;
        @(negedge clk);
        we_s[k] = w; re_s[k] = r; addr_s[k] = a; din_s[k] = d;
        sb.push_back('{k, !w, exp_d, exp_e});
        @(posedge clk); #1;
        we_s[k] = 1'b0; re_s[k] = poke; addr_s[k] = ~a; din_s[k] = ~d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdy_s[k] !== 1'b1 && n < 40);
        re_s[k] = 1'b0;
        chk(n == LAT[k], "latency", n, LAT[k]);
        @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            re_s[k] = 0; we_s[k] = 0; addr_s[k] = 0; din_s[k] = 0;
        end
        res = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(rdy_s[k] === 1'b0, "reset_ready", rdy_s[k], 0);
            chk(busy_s[k] === 1'b0, "reset_busy", busy_s[k], 0);
            chk(dout_s[k] === 32'h0, "reset_dout", dout_s[k], 0);
        end
        repeat (10) begin
            @(negedge clk);
            chk(rdy_s[1] === 1'b0, "idle_ready", rdy_s[1], 0);
        end

        // Basic write/read, latency 2, hold and aliasing
        xact(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
        xact(1, 0, 1, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
        repeat (3) @(negedge clk);
        chk(dout_s[1] === 32'hDEADBEEF, "dout_hold", dout_s[1], 32'hDEADBEEF);
        chk(busy_s[1] === 1'b0, "idle_busy", busy_s[1], 0);
        xact(1, 0, 1, 32'h4010, 32'h0, 0, 32'hDEADBEEF, 0);
        xact(1, 1, 0, 32'h14, 32'h1, 0, 0, 0);
        @(negedge clk);
        chk(dout_s[1] === 32'hDEADBEEF, "dout_hold_after_write", dout_s[1], 32'hDEADBEEF);

        // Refill-style burst at latency 1
        for (int i = 0; i < 256; i++) xact(0, 1, 0, i * 4, i, 0, 0, 0);
        for (int i = 0; i < 256; i++) xact(0, 0, 1, i * 4, 0, 0, i, 0);

        // re+we -> write; read poked during wait ignored
        xact(1, 1, 1, 32'h20, 32'h5, 1, 0, 0);
        xact(1, 0, 1, 32'h20, 32'h0, 0, 32'h5, 0);

        // Reset during the second wait cycle of a latency-4 write
        xact(2, 1, 0, 32'h30, 32'h11, 0, 0, 0);
        @(negedge clk);
        we_s[2] = 1'b1; addr_s[2] = 32'h30; din_s[2] = 32'hAA;
        @(posedge clk); #1;
        we_s[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        chk(busy_s[2] === 1'b0, "reset_mid_busy", busy_s[2], 0);
        chk(rdy_s[2] === 1'b0, "reset_mid_ready", rdy_s[2], 0);
        chk(dout_s[1] === 32'h0, "reset_mid_dout", dout_s[1], 0);
        res = 1'b1;
        repeat (6) @(negedge clk);
        xact(2, 0, 1, 32'h30, 32'h0, 0, 32'h11, 0);

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
        xact(1, 1, 0, 32'h40, 32'h1234, 0, 0, 0);
        xact(1, 1, 0, 32'h41, 32'h7, 0, 0, 1);
        xact(1, 0, 1, 32'h40, 32'h0, 0, 32'h1234, 0);
        xact(1, 0, 1, 32'h42, 32'h0, 0, 32'h0, 1);
`endif

        repeat (5) @(negedge clk);
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
